// File: rtl/dmem_slave.sv
// dmem_slave: byte-addressed, big-endian data memory with one memory-mapped
// GPIO output register, behind a single-outstanding request/response port.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1 (req_ready is 1 only in IDLE, and during reset); a
// response transfers on a rising edge where rsp_valid and rsp_ready are both
// 1. rsp_rdata/rsp_err are held stable while rsp_valid=1 and rsp_ready=0, and
// rsp_ready is ignored while rsp_valid=0.
module dmem_slave #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] GPIO_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  gpio
);

  localparam int AW = $clog2(DEPTH_BYTES);
  // Counter reload value: WAIT lasts (WS_LAST + 1) = WAIT_STATES cycles.
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_resp;

  // Request fields captured at acceptance.
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;

  // Operation being executed: with zero wait states the commit edge is the
  // acceptance edge itself, so the live request is used while in IDLE.
  logic        op_we;
  logic [31:0] op_addr;
  logic [2:0]  op_funct3;
  logic [31:0] op_wdata;

  logic        is_gpio, in_mem, bad_f3, misalign, op_err;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [31:0] raw, ext, load_data;

  logic [7:0]  mem [DEPTH_BYTES];
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  gpio_q;

  assign req_ready = rst || (state_q == IDLE);
  assign rsp_valid = !rst && (state_q == RESP);
  assign rsp_rdata = rst ? 32'h0 : rdata_q;
  assign rsp_err   = !rst && err_q;
  assign gpio      = rst ? 8'h00 : gpio_q;

  assign op_we     = (state_q == IDLE) ? req_we     : lat_we;
  assign op_addr   = (state_q == IDLE) ? req_addr   : lat_addr;
  assign op_funct3 = (state_q == IDLE) ? req_funct3 : lat_funct3;
  assign op_wdata  = (state_q == IDLE) ? req_wdata  : lat_wdata;

  // Next-state logic; enter_resp marks the commit/capture edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LAST;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture all request fields on the accepting edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_funct3 <= 3'b000;
      lat_wdata  <= 32'h0;
    end else if (state_q == IDLE && req_valid) begin
      lat_we     <= req_we;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end
  end

  // Access decode: width legality, alignment, address map.
  always_comb begin
    is_gpio  = (op_addr == GPIO_ADDR);
    in_mem   = (op_addr < DEPTH_BYTES);
    bad_f3   = (op_funct3 == 3'b011) || (op_funct3 == 3'b110) || (op_funct3 == 3'b111);
    misalign = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
               ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    op_err   = bad_f3 || (op_we && op_funct3[2]) || misalign || !(is_gpio || in_mem);
    i0 = op_addr[AW-1:0];
    i1 = i0 + AW'(1);
    i2 = i0 + AW'(2);
    i3 = i0 + AW'(3);
  end

  // Load path: big-endian fetch, then sign/zero extension by width code.
  always_comb begin
    raw = 32'h0;
    if (is_gpio) begin
      raw = {24'h0, gpio_q};
    end else begin
      case (op_funct3[1:0])
        2'b00:   raw = {24'h0, mem[i0]};
        2'b01:   raw = {16'h0, mem[i0], mem[i1]};
        default: raw = {mem[i0], mem[i1], mem[i2], mem[i3]};
      endcase
    end
    case (op_funct3)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  ext = raw;
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
    load_data = (op_err || op_we) ? 32'h0 : ext;
  end

  // Response registers, captured on the edge entering RESP and held there.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= load_data;
      err_q   <= op_err;
    end
  end

  // GPIO register: any legal store to GPIO_ADDR takes the low data byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q <= 8'h00;
    end else if (enter_resp && op_we && !op_err && is_gpio) begin
      gpio_q <= op_wdata[7:0];
    end
  end

  // Memory store commit; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we && !op_err && !is_gpio) begin
      case (op_funct3[1:0])
        2'b00: mem[i0] <= op_wdata[7:0];
        2'b01: begin
          mem[i0] <= op_wdata[15:8];
          mem[i1] <= op_wdata[7:0];
        end
        default: begin
          mem[i0] <= op_wdata[31:24];
          mem[i1] <= op_wdata[23:16];
          mem[i2] <= op_wdata[15:8];
          mem[i3] <= op_wdata[7:0];
        end
      endcase
    end
  end

endmodule
